dta_egr_rcv_responder: RTL
==========================

DTA_EGR_RCV_RESPONDER -- requirements
Module: dta_egr_rcv_responder

Interface
REQ-001 SHALL have parameter MAX_BURST, default 4096, meaning the maximum granted burst length in bytes; it SHALL be a multiple of 64 in the range 64..65472.
REQ-002 SHALL have port ap_clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-003 SHALL have port ap_rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have ports req_tvalid (in, 1), req_tready (out, 1) and req_tdata (in, 64): the request stream. Field layout: [8:0] channel, [30] eof, [31] sof, [63:48] burst_length in bytes, all other bits ignored.
REQ-005 SHALL have ports resp_tvalid (out, 1), resp_tready (in, 1) and resp_tdata (out, 64): the response stream, with the same field layout as req_tdata and all unused bits 0.
REQ-006 SHALL have ports s_data_tvalid (in, 1), s_data_tready (out, 1) and s_data_tdata (in, 512): the upstream payload, one 64-byte beat per transfer.
REQ-007 SHALL have ports data_tvalid (out, 1), data_tready (in, 1) and data_tdata (out, 512): the payload stream to the receiver.
REQ-008 SHALL have port grant_limit, input, 16 bits: bytes currently grantable, sampled at request acceptance.
REQ-009 SHALL have port busy, output, 1 bit: high when the state is not IDLE.
REQ-010 SHALL have ports req_count, resp_count and beat_count, outputs, 32 bits each: accepted requests, accepted responses and data beats, each wrapping modulo 2^32.

Function
REQ-011 SHALL implement the states IDLE, RESP and DATA.
REQ-012 SHALL drive req_tready high only in IDLE, combinationally from the state.
REQ-013 SHALL, on a req handshake in IDLE, register channel, sof and eof and compute the grant G = min(req burst_length, grant_limit, MAX_BURST) on 16 bits, then move to RESP.
REQ-014 SHALL, in RESP, hold resp_tvalid high with a stable resp_tdata until resp_tready is high: channel, sof and eof copied from the request, burst_length = G.
REQ-015 SHALL assert resp_tvalid in the cycle after the req handshake, giving a request-to-response latency of 1 cycle.
REQ-016 SHALL, on a resp handshake with G = 0, return to IDLE with no data beats; a request with burst_length 0 SHALL therefore produce a response with burst_length 0.
REQ-017 SHALL, on a resp handshake with G > 0, load the beat counter with ceil(G/64), computed as (G+63)>>6 on 17 bits, and move to DATA.
REQ-018 SHALL, in DATA, pass beats through combinationally: data_tvalid = s_data_tvalid, s_data_tready = data_tready, data_tdata = s_data_tdata.
REQ-019 SHALL hold data_tvalid and s_data_tready low outside DATA.
REQ-020 SHALL decrement the beat counter on each data handshake and return to IDLE on the handshake that takes the counter from 1 to 0.
REQ-021 SHALL NOT issue any data beat before the resp handshake of the same transaction.
REQ-022 SHALL NOT issue more beats than ceil(G/64).
REQ-023 SHALL allow at most one transaction outstanding.
REQ-024 SHALL allow a new request to be accepted in the cycle after the return to IDLE, giving a minimum of 1 idle cycle between transactions.
REQ-025 SHALL increment req_count, resp_count and beat_count on their respective handshakes; a counter at 0xFFFFFFFF SHALL wrap to 0.
REQ-026 SHALL ignore changes to grant_limit after the request has been sampled.
REQ-027 SHALL tolerate backpressure on resp_tready or data_tready of any duration without losing or duplicating a beat.

Reset
REQ-028 SHALL, while ap_rst is high at a clock edge, force the state to IDLE and clear the beat counter, the registered fields, all counts and resp_tdata to 0.
REQ-029 SHALL hold resp_tvalid, data_tvalid, s_data_tready and busy at 0 during reset, and req_tready at 0 while ap_rst is high.
REQ-030 SHALL, when reset is asserted mid-transaction, abandon the transaction with no further resp or data handshakes; IDLE SHALL be reached on the first edge after ap_rst falls.

Verification
REQ-031 SHALL cover: req burst_length 256, grant_limit 0xFFFF -> resp burst_length 256 one cycle after the req handshake, then exactly 4 data beats, then busy = 0.
REQ-032 SHALL cover: req 8192 with MAX_BURST 4096 -> resp burst_length 4096 and 64 beats; req 100 with grant_limit 70 -> resp 70 and 2 beats.
REQ-033 SHALL cover: req burst_length 0, or grant_limit 0 -> resp burst_length 0 with sof, eof and channel echoed, no data beats, and a return to IDLE.
REQ-034 SHALL cover: resp_tready held low for 10 cycles and random data_tready/s_data_tvalid stalls -> resp_tdata stable throughout, beat order preserved, beat_count equal to the expected number of beats.
REQ-035 SHALL cover: ap_rst pulsed during DATA after 2 of 4 beats -> all outputs 0, then the next request is served normally with counts restarted from 0.
REQ-036 SHALL cover: 1000 random transactions run through the egress receive protocol monitor -> protocol_error stays 0x0000.

Source files
------------

// File: rtl/dta_egr_rcv_responder.sv
// rtl/dta_egr_rcv_responder.sv - egress receive responder: grants request bursts and forwards payload beats
module dta_egr_rcv_responder #(
    parameter int MAX_BURST = 4096
) (
    input  logic         ap_clk,
    input  logic         ap_rst,
    input  logic         req_tvalid,
    output logic         req_tready,
    input  logic [63:0]  req_tdata,
    output logic         resp_tvalid,
    input  logic         resp_tready,
    output logic [63:0]  resp_tdata,
    input  logic         s_data_tvalid,
    output logic         s_data_tready,
    input  logic [511:0] s_data_tdata,
    output logic         data_tvalid,
    input  logic         data_tready,
    output logic [511:0] data_tdata,
    input  logic [15:0]  grant_limit,
    output logic         busy,
    output logic [31:0]  req_count,
    output logic [31:0]  resp_count,
    output logic [31:0]  beat_count
);
    typedef enum logic [1:0] {
        IDLE,
        RESP,
        DATA
    } state_t;

    localparam logic [15:0] MAX_BURST_W = 16'(MAX_BURST);

    state_t      state;
    state_t      state_nxt;
    logic [16:0] beats_left;
    logic [15:0] grant_q;
    logic [15:0] req_grant;
    logic [16:0] grant_beats;
    logic        req_hs;
    logic        resp_hs;
    logic        data_hs;

    always_comb begin
        req_grant = req_tdata[63:48];
        if (grant_limit < req_grant) req_grant = grant_limit;
        if (MAX_BURST_W < req_grant) req_grant = MAX_BURST_W;
    end

    assign grant_beats = ({1'b0, grant_q} + 17'd63) >> 6;

    assign req_hs  = req_tvalid && req_tready;
    assign resp_hs = resp_tvalid && resp_tready;
    assign data_hs = data_tvalid && data_tready;

    // Every handshake output is gated by reset so nothing can complete while ap_rst is high.
    always_comb begin
        state_nxt     = state;
        req_tready    = 1'b0;
        resp_tvalid   = 1'b0;
        s_data_tready = 1'b0;
        data_tvalid   = 1'b0;
        data_tdata    = '0;
        busy          = 1'b0;
        if (!ap_rst) begin
            case (state)
                IDLE: begin
                    req_tready = 1'b1;
                    if (req_tvalid) state_nxt = RESP;
                end
                RESP: begin
                    busy        = 1'b1;
                    resp_tvalid = 1'b1;
                    if (resp_tready) state_nxt = (grant_q == 16'd0) ? IDLE : DATA;
                end
                DATA: begin
                    busy          = 1'b1;
                    data_tvalid   = s_data_tvalid;
                    s_data_tready = data_tready;
                    data_tdata    = s_data_tdata;
                    if (s_data_tvalid && data_tready && beats_left == 17'd1) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state      <= IDLE;
            beats_left <= '0;
            grant_q    <= '0;
            resp_tdata <= '0;
            req_count  <= '0;
            resp_count <= '0;
            beat_count <= '0;
        end else begin
            state <= state_nxt;
            if (req_hs) begin
                grant_q    <= req_grant;
                resp_tdata <= {req_grant, 16'h0000, req_tdata[31], req_tdata[30], 21'h0, req_tdata[8:0]};
                req_count  <= req_count + 32'd1;
            end
            if (resp_hs) begin
                beats_left <= grant_beats;
                resp_count <= resp_count + 32'd1;
            end
            if (data_hs) begin
                beats_left <= beats_left - 17'd1;
                beat_count <= beat_count + 32'd1;
            end
        end
    end
endmodule
